// File: rtl/rv32i_mem_pkg.sv
// Shared types and constants for the RV32I unified-memory arbiter.
// Holds the response-owner encoding, the memory request bundle at the default
// widths, grant vector bit positions and the last-winner encoding.
package rv32i_mem_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 4;

    // Starvation counter width; covers the full 1..15 range of STARVE_MAX.
    localparam int CNT_W = 4;

    // One-hot grant vector bit positions.
    localparam int GNT_IF = 0;
    localparam int GNT_D  = 1;

    // Winner of the most recent contested cycle (round-robin build).
    localparam logic LAST_IF = 1'b0;
    localparam logic LAST_D  = 1'b1;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_D    = 2'd2
    } rsp_owner_e;

    typedef struct packed {
        logic                      en;
        logic                      we;
        logic [DEF_DATA_W/8-1:0]   be;
        logic [DEF_ADDR_W-1:0]     addr;
        logic [DEF_DATA_W-1:0]     wdata;
    } mem_req_t;

endpackage

// File: rtl/rv32i_mem_arbiter_arb_pick.sv
// arb_pick: combinational winner selection between fetch and data requests.
// Ports: if_req, d_req, policy state (starve_cnt, or last_win when
// ARB_ROUND_ROBIN_EN is defined); gnt is one-hot {d, if} or zero when idle.
`ifdef ARB_ROUND_ROBIN_EN
module arb_pick
    import rv32i_mem_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
    input  logic       last_win,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = 2'b00;
        if (if_req && d_req) begin
            // Contested: hand the cycle to whoever lost the last contest.
            if (last_win == LAST_IF) gnt[GNT_D]  = 1'b1;
            else                     gnt[GNT_IF] = 1'b1;
        end else if (d_req) begin
            gnt[GNT_D] = 1'b1;
        end else if (if_req) begin
            gnt[GNT_IF] = 1'b1;
        end
    end
endmodule
`else
module arb_pick
    import rv32i_mem_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic             if_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic [1:0]       gnt
);
    always_comb begin
        gnt = 2'b00;
        // Data normally wins; a fetch that has waited STARVE_MAX data grants
        // takes the cycle.
        if (if_req && (starve_cnt == CNT_W'(STARVE_MAX))) begin
            gnt[GNT_IF] = 1'b1;
        end else if (d_req) begin
            gnt[GNT_D] = 1'b1;
        end else if (if_req) begin
            gnt[GNT_IF] = 1'b1;
        end
    end
endmodule
`endif

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares one single-cycle-latency memory between the fetch
// and load/store ports; grants are same-cycle, read data returns one cycle later
// to the port that issued the read. Optional macro: ARB_ROUND_ROBIN_EN.
module rv32i_mem_arbiter
    import rv32i_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int BE_W = DATA_W / 8;

    typedef struct packed {
        logic              en;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    logic [1:0] pick_gnt;
    logic [1:0] gnt;
    req_t       mem_req;
    rsp_owner_e rsp_owner_q, rsp_owner_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_win_q, last_win_d;

    arb_pick u_arb_pick (
        .if_req   (if_req),
        .d_req    (d_req),
        .last_win (last_win_q),
        .gnt      (pick_gnt)
    );
`else
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .starve_cnt (starve_cnt_q),
        .gnt        (pick_gnt)
    );
`endif

    // Grants and memory request; nothing is granted while reset is held so
    // every output reads 0 during reset.
    always_comb begin
        gnt     = rst ? 2'b00 : pick_gnt;
        if_gnt  = gnt[GNT_IF];
        d_gnt   = gnt[GNT_D];
        mem_req = '0;
        if (d_gnt) begin
            mem_req.en    = 1'b1;
            mem_req.we    = d_we;
            mem_req.be    = d_be;
            mem_req.addr  = d_addr;
            mem_req.wdata = d_wdata;
        end else if (if_gnt) begin
            // Instruction fetch is always a full-word read.
            mem_req.en    = 1'b1;
            mem_req.be    = '1;
            mem_req.addr  = if_addr;
        end
    end

    assign mem_en    = mem_req.en;
    assign mem_we    = mem_req.we;
    assign mem_be    = mem_req.be;
    assign mem_addr  = mem_req.addr;
    assign mem_wdata = mem_req.wdata;

    // Next-state: response owner plus the arbitration policy state.
    always_comb begin
        rsp_owner_d = RSP_NONE;
        if (if_gnt)                rsp_owner_d = RSP_IF;
        else if (d_gnt && !d_we)   rsp_owner_d = RSP_D;
`ifdef ARB_ROUND_ROBIN_EN
        last_win_d = last_win_q;
        // Only contested cycles move the round-robin pointer.
        if (if_req && d_req && (if_gnt || d_gnt)) last_win_d = d_gnt ? LAST_D : LAST_IF;
`else
        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_gnt) begin
            starve_cnt_d = '0;
        end else if (d_gnt && (starve_cnt_q != CNT_W'(STARVE_MAX))) begin
            // Saturates at STARVE_MAX rather than wrapping.
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_owner_q  <= RSP_NONE;
`ifdef ARB_ROUND_ROBIN_EN
            last_win_q   <= LAST_IF;
`else
            starve_cnt_q <= '0;
`endif
        end else begin
            rsp_owner_q  <= rsp_owner_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_win_q   <= last_win_d;
`else
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    // Response steering; the non-owning port's data is forced to 0.
    assign if_rvalid = (rsp_owner_q == RSP_IF);
    assign d_rvalid  = (rsp_owner_q == RSP_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule

// File: doc/rv32i_mem_arbiter.md
# rv32i_mem_arbiter

Arbitrates a single-port, single-cycle-latency unified memory between the RV32I core's instruction-fetch port and its load/store port. It sits between `RV32I_core` and a unified `unified_mem` in the top level, replacing separate instruction and data memories. Both requesters use a req/gnt/rvalid handshake. The arbiter routes read responses back to the port that issued the read.

## Interface
Parameters:
- `ADDR_W`, 32: byte address width.
- `DATA_W`, 32: data width; byte enables are `DATA_W/8` bits wide.
- `STARVE_MAX`, 4: maximum consecutive data grants while a fetch is waiting. Range 1..15.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state is updated on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held until granted.
- `if_addr`  in  ADDR_W  fetch address; word aligned.
- `if_gnt`  out  1  fetch accepted this cycle.
- `if_rvalid`  out  1  `if_rdata` is valid.
- `if_rdata`  out  DATA_W  fetched instruction.
- `d_req`  in  1  load/store request; held until granted.
- `d_we`  in  1  1 = store, 0 = load.
- `d_be`  in  DATA_W/8  store byte enables.
- `d_addr`  in  ADDR_W  load/store address.
- `d_wdata`  in  DATA_W  store data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  load data valid; never asserted for stores.
- `d_rdata`  out  DATA_W  load data.
- `mem_en`  out  1  memory access this cycle.
- `mem_we`  out  1  memory write.
- `mem_be`  out  DATA_W/8  memory byte enables.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  read data, valid one cycle after `mem_en` with `!mem_we`.

## Operation
Arbitration:
- Every cycle with `if_req | d_req` grants exactly one requester.
- The grant is combinational from the requests and registered state.
- `mem_*` is driven from the granted port in the same cycle.
- With no request: `mem_en=0`, and the other `mem_*` outputs are 0.

Default priority:
- Data beats fetch, so loads and stores can retire.
- Starvation counter `starve_cnt`:
  - Increments on each data grant while `if_req` is high.
  - Clears on any fetch grant, or on any cycle where `if_req` is low.
  - When `starve_cnt == STARVE_MAX` and `if_req` is high, fetch wins that cycle regardless of `d_req`.
- Stores are granted like loads but produce no rvalid.

Response routing:
- Register `rsp_owner` holds the response destination: `{NONE, IF, D}`.
- It is loaded on each granted read and set to NONE on a store or an idle cycle.
- In the cycle after a grant, `rsp_owner` steers `mem_rdata` to `if_rdata` or `d_rdata` and pulses the matching rvalid.
- A new grant may occur in the same cycle as a response, so the path is fully pipelined at one access per cycle.
- The rdata output of the non-owning port holds 0.

## Timing
- Grant latency: 0 cycles (gnt in the same cycle as req when selected).
- Read latency: rvalid exactly 1 cycle after gnt.
- Reset values:
  - All gnt/rvalid outputs 0; all rdata outputs 0.
  - `mem_en=0`, `mem_we=0`, `mem_be=0`, `mem_addr=0`, `mem_wdata=0`.
  - `rsp_owner=NONE`, `starve_cnt=0`.
- Reset mid-operation: an outstanding read response is dropped; no rvalid follows reset deassertion.
- Both requests at the starvation limit: fetch is granted, `starve_cnt` clears, data is granted next cycle.
- A request that drops without a grant is legal and creates no state.
- `starve_cnt` saturates at `STARVE_MAX`; it never wraps.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - The starvation counter is removed.
  - On simultaneous requests, the port that did not win the last contested cycle is granted.
  - A one-bit `last_win` register resets to IF, so data wins the first contest.
- Not defined: data priority with the `STARVE_MAX` guard, as described under Operation.

## Structure
- Package `rv32i_mem_pkg`:
  - enum `rsp_owner_e` {NONE, IF, D}.
  - typedef `mem_req_t` (en, we, be, addr, wdata).
  - Default width constants.
- One sub-module is natural: `arb_pick`.
  - Pure combinational winner selection.
  - Inputs: requests, `starve_cnt` or `last_win`.
  - Output: one-hot grant.
  - Keeps the macro-dependent policy isolated from the datapath mux and the response routing.

## Test plan
- Reset release, then `if_req` alone at `if_addr=0x10` → `if_gnt` and `mem_addr=0x10` in the same cycle; `if_rvalid=1` with `if_rdata=mem_rdata` next cycle; `d_rvalid=0`.
- `d_req` load and `if_req` together, one cycle → `d_gnt=1`, `if_gnt=0`; next cycle `d_rvalid=1` while `if_gnt=1`.
- Store with `d_be=4'b0011` → `mem_we=1`, `mem_be=0011`, no `d_rvalid` the following cycle.
- Default build, `STARVE_MAX=4`, `d_req` and `if_req` held continuously → 4 data grants, 1 fetch grant, repeating.
- `ARB_ROUND_ROBIN_EN` build, both held continuously → grants alternate D, IF, D, IF, ...
- Assert `rst` in the cycle after a granted fetch → no `if_rvalid` and all outputs 0 during and after reset.
